// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the PLL clock monitor: FSM state encoding and
// per-output default window/expectation constants (1 ms window at 50 MHz).
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EVAL    = 2'd2
    } state_t;

    // PWMClock: 1 MHz -> 1000 edges per 1 ms window
    localparam int unsigned PWM_CLK_GATE_CYCLES  = 50000;
    localparam int unsigned PWM_CLK_EXP_COUNT    = 1000;
    localparam int unsigned PWM_CLK_TOL          = 2;

    // HornClock: 440 kHz -> 440 edges per 1 ms window
    localparam int unsigned HORN_CLK_GATE_CYCLES = 50000;
    localparam int unsigned HORN_CLK_EXP_COUNT   = 440;
    localparam int unsigned HORN_CLK_TOL         = 2;

    // IMUI2CClock: 400 kHz -> 400 edges per 1 ms window
    localparam int unsigned IMU_I2C_CLK_GATE_CYCLES = 50000;
    localparam int unsigned IMU_I2C_CLK_EXP_COUNT   = 400;
    localparam int unsigned IMU_I2C_CLK_TOL         = 1;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer for an asynchronous clock plus a registered
// rising-edge detector; the pulse appears 3 cycles after the input rises.
module edge_sync_detect
    import clock_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Synchronize, delay one more stage, and register the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            sync_q3    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q1    <= async_in;
            sync_q2    <= sync_q1;
            sync_q3    <= sync_q2;
            rise_pulse <= sync_q2 & ~sync_q3;
        end
    end

endmodule

// File: rtl/clock_monitor.sv
// Frequency monitor for a PLL output: counts mon_clk rising edges over a
// GATE_CYCLES window of CLOCK_50 and flags counts outside EXP_COUNT +/- TOL.
// Optional macro CLOCK_MONITOR_STICKY_FAULT_EN makes fault latch until fault_clr.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = PWM_CLK_GATE_CYCLES,
    parameter int unsigned EXP_COUNT   = PWM_CLK_EXP_COUNT,
    parameter int unsigned TOL         = PWM_CLK_TOL,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             areset,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             stuck,
    output logic             fault
);

    localparam int unsigned WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned DEV_W = CNT_W + 1;
    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic signed [DEV_W-1:0] EXP_S    = DEV_W'(EXP_COUNT);

    state_t             state;
    state_t             state_nxt_c;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIN_W-1:0]   win_nxt_c;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   edge_nxt_c;
    logic               load_c;
    logic               drop_c;
    logic               edge_pulse;
    logic signed [DEV_W-1:0] dev_c;
    logic [DEV_W-1:0]   abs_dev_c;
    logic               in_tol_c;

    edge_sync_detect u_sync (
        .clk        (CLOCK_50),
        .rst        (areset),
        .async_in   (mon_clk),
        .rise_pulse (edge_pulse)
    );

    // Signed deviation from the expected count; one extra bit so it never wraps
    always_comb begin
        dev_c     = $signed({1'b0, edge_cnt}) - EXP_S;
        abs_dev_c = dev_c[DEV_W-1] ? DEV_W'(-dev_c) : DEV_W'(dev_c);
        in_tol_c  = (32'(abs_dev_c) <= TOL);
    end

    // State register
    always_ff @(posedge CLOCK_50 or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt_c;
        end
    end

    // Next-state, counter next values and result-load strobes
    always_comb begin
        state_nxt_c = state;
        win_nxt_c   = win_cnt;
        edge_nxt_c  = edge_cnt;
        load_c      = 1'b0;
        drop_c      = 1'b0;
        case (state)
            IDLE: begin
                win_nxt_c  = '0;
                edge_nxt_c = '0;
                if (enable) begin
                    state_nxt_c = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nxt_c = IDLE;
                    win_nxt_c   = '0;
                    edge_nxt_c  = '0;
                    drop_c      = 1'b1;
                end else begin
                    if (edge_pulse && (edge_cnt != CNT_MAX)) begin
                        edge_nxt_c = edge_cnt + CNT_W'(1);
                    end
                    if (win_cnt == WIN_LAST) begin
                        state_nxt_c = EVAL;
                        win_nxt_c   = '0;
                    end else begin
                        win_nxt_c = win_cnt + WIN_W'(1);
                    end
                end
            end
            EVAL: begin
                win_nxt_c = '0;
                if (!enable) begin
                    state_nxt_c = IDLE;
                    edge_nxt_c  = '0;
                    drop_c      = 1'b1;
                end else begin
                    state_nxt_c = MEASURE;
                    load_c      = 1'b1;
                    // An edge seen during EVAL belongs to the next window
                    edge_nxt_c  = edge_pulse ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_nxt_c = IDLE;
                win_nxt_c   = '0;
                edge_nxt_c  = '0;
            end
        endcase
    end

    // Window and edge counters
    always_ff @(posedge CLOCK_50 or posedge areset) begin
        if (areset) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_nxt_c;
            edge_cnt <= edge_nxt_c;
        end
    end

    // Measurement results; freq_ok cleared when a window is abandoned
    always_ff @(posedge CLOCK_50 or posedge areset) begin
        if (areset) begin
            meas_count <= '0;
            meas_valid <= 1'b0;
            freq_ok    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= load_c;
            if (load_c) begin
                meas_count <= edge_cnt;
                freq_ok    <= in_tol_c;
                stuck      <= (edge_cnt == '0);
            end else if (drop_c) begin
                freq_ok <= 1'b0;
            end
        end
    end

`ifdef CLOCK_MONITOR_STICKY_FAULT_EN
    // Sticky fault: a failing evaluation wins over a simultaneous clear
    always_ff @(posedge CLOCK_50 or posedge areset) begin
        if (areset) begin
            fault <= 1'b0;
        end else if (load_c && !in_tol_c) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end
`else
    logic fault_clr_unused;
    assign fault_clr_unused = fault_clr;

    // Fault mirrors the inverse of each new freq_ok result
    always_ff @(posedge CLOCK_50 or posedge areset) begin
        if (areset) begin
            fault <= 1'b0;
        end else if (load_c) begin
            fault <= !in_tol_c;
        end
    end
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: a main instance (1000-cycle window,
// 20 +/- 1 edges) and a narrow-counter instance (CNT_W=4, 30 edges/window).
module tb_clock_monitor;

    localparam int unsigned G    = 1000;
    localparam int unsigned EXP  = 20;
    localparam int unsigned TOLV = 1;
    localparam int unsigned CW   = 16;
    localparam int unsigned G2   = 120;
    localparam int unsigned EXP2 = 15;
    localparam int unsigned TOL2 = 0;
    localparam int unsigned CW2  = 4;

`ifdef CLOCK_MONITOR_STICKY_FAULT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic          areset;
    logic          mon_clk;
    logic          enable;
    logic          fault_clr;
    logic [CW-1:0] meas_count;
    logic          meas_valid;
    logic          freq_ok;
    logic          stuck;
    logic          fault;

    logic           mon_clk2;
    logic           en2;
    logic           fault_clr2;
    logic [CW2-1:0] meas_count2;
    logic           meas_valid2;
    logic           freq_ok2;
    logic           stuck2;
    logic           fault2;

    clock_monitor #(.GATE_CYCLES(G), .EXP_COUNT(EXP), .TOL(TOLV), .CNT_W(CW)) dut (
        .CLOCK_50   (CLOCK_50),
        .areset     (areset),
        .mon_clk    (mon_clk),
        .enable     (enable),
        .fault_clr  (fault_clr),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .freq_ok    (freq_ok),
        .stuck      (stuck),
        .fault      (fault)
    );

    clock_monitor #(.GATE_CYCLES(G2), .EXP_COUNT(EXP2), .TOL(TOL2), .CNT_W(CW2)) dut_narrow (
        .CLOCK_50   (CLOCK_50),
        .areset     (areset),
        .mon_clk    (mon_clk2),
        .enable     (en2),
        .fault_clr  (fault_clr2),
        .meas_count (meas_count2),
        .meas_valid (meas_valid2),
        .freq_ok    (freq_ok2),
        .stuck      (stuck2),
        .fault      (fault2)
    );

    int tests;
    int fails;
    int mon_period;
    int mon_ph;
    int mon2_ph;

    typedef struct {
        int period;
        int cnt;
        bit ok;
        bit stk;
        bit flt;
        bit clr;
        bit flt_after_clr;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n falling edges; mon clocks are driven here so phase is exact
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            if (mon_period == 0) begin
                mon_ph  = 0;
                mon_clk = 1'b0;
            end else begin
                mon_ph  = (mon_ph + 1) % mon_period;
                mon_clk = (mon_ph >= mon_period / 2);
            end
            mon2_ph  = (mon2_ph + 1) % 4;
            mon_clk2 = (mon2_ph >= 2);
        end
    endtask

    task automatic start_mon(input int p);
        mon_period = p;
        mon_ph     = 0;
        mon_clk    = 1'b0;
    endtask

    task automatic restart(input int p);
        enable = 1'b0;
        start_mon(0);
        cycles(4);
        start_mon(p);
        enable = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " count"}, int'(meas_count), v.cnt);
        check({tag, " freq_ok"}, int'(freq_ok), int'(v.ok));
        check({tag, " stuck"}, int'(stuck), int'(v.stk));
        check({tag, " fault"}, int'(fault), int'(v.flt));
    endtask

    initial begin
        bit mv_seen;
        tests      = 0;
        fails      = 0;
        mon_period = 0;
        mon_ph     = 0;
        mon2_ph    = 0;
        areset     = 1'b1;
        enable     = 1'b0;
        fault_clr  = 1'b0;
        fault_clr2 = 1'b0;
        en2        = 1'b0;
        mon_clk    = 1'b0;
        mon_clk2   = 1'b0;

        vecs[0] = '{50, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0,  0,  1'b0, 1'b1, 1'b1, 1'b1, !STICKY};
        vecs[2] = '{40, 25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{50, 20, 1'b1, 1'b0, STICKY, 1'b1, 1'b0};

        cycles(2);
        check("reset count", int'(meas_count), 0);
        check("reset valid", int'(meas_valid), 0);
        check("reset freq_ok", int'(freq_ok), 0);
        check("reset stuck", int'(stuck), 0);
        check("reset fault", int'(fault), 0);
        areset = 1'b0;
        en2    = 1'b1;
        cycles(2);

        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            restart(vecs[i].period);
            cycles(1001);
            check({tag, " valid early"}, int'(meas_valid), 0);
            cycles(1);
            check({tag, " valid w1"}, int'(meas_valid), 1);
            check_outputs({tag, " w1"}, vecs[i]);
            cycles(1);
            check({tag, " valid pulse"}, int'(meas_valid), 0);
            cycles(1000);
            check({tag, " valid w2"}, int'(meas_valid), 1);
            check_outputs({tag, " w2"}, vecs[i]);
            if (vecs[i].clr) begin
                fault_clr = 1'b1;
                cycles(1);
                fault_clr = 1'b0;
                cycles(1);
                check({tag, " fault after clr"}, int'(fault), int'(vecs[i].flt_after_clr));
            end
            if (i == 0) begin
                check("narrow count", int'(meas_count2), 15);
                check("narrow freq_ok", int'(freq_ok2), 1);
                check("narrow stuck", int'(stuck2), 0);
                check("narrow fault", int'(fault2), 0);
            end
        end

        // enable dropped mid-window: no result, freq_ok cleared, count held
        restart(50);
        cycles(501);
        enable = 1'b0;
        start_mon(0);
        mv_seen = 1'b0;
        for (int k = 0; k < 700; k++) begin
            cycles(1);
            if (meas_valid) mv_seen = 1'b1;
        end
        check("drop no valid", int'(mv_seen), 0);
        check("drop freq_ok", int'(freq_ok), 0);
        check("drop count held", int'(meas_count), 20);
        check("drop stuck held", int'(stuck), 0);
        start_mon(50);
        enable = 1'b1;
        cycles(1001);
        check("reenable valid early", int'(meas_valid), 0);
        cycles(1);
        check("reenable valid", int'(meas_valid), 1);
        check("reenable count", int'(meas_count), 20);
        check("reenable freq_ok", int'(freq_ok), 1);

        // asynchronous reset mid-window clears outputs before any clock edge
        cycles(300);
        areset = 1'b1;
        #1;
        check("areset count", int'(meas_count), 0);
        check("areset valid", int'(meas_valid), 0);
        check("areset freq_ok", int'(freq_ok), 0);
        check("areset stuck", int'(stuck), 0);
        check("areset fault", int'(fault), 0);
        check("areset narrow count", int'(meas_count2), 0);
        start_mon(0);
        cycles(3);
        areset = 1'b0;
        start_mon(50);
        cycles(1001);
        check("post reset valid early", int'(meas_valid), 0);
        cycles(1);
        check("post reset valid", int'(meas_valid), 1);
        check("post reset count", int'(meas_count), 20);
        check("post reset freq_ok", int'(freq_ok), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, measurement window length in CLOCK_50 cycles (1 ms); legal range >= 2.
REQ-002 SHALL have parameter EXP_COUNT, default 1000, expected rising edges of mon_clk per window.
REQ-003 SHALL have parameter TOL, default 2, allowed absolute deviation from EXP_COUNT.
REQ-004 SHALL have parameter CNT_W, default 16, edge-counter width.
REQ-005 SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port areset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port mon_clk  input  1  PLL output under test, asynchronous to CLOCK_50, frequency < 25 MHz.
REQ-008 SHALL have port enable  input  1  level; high runs continuous measurement.
REQ-009 SHALL have port fault_clr  input  1  single-cycle pulse, clears latched fault.
REQ-010 SHALL have port meas_count  output  CNT_W  edge count of the last completed window.
REQ-011 SHALL have port meas_valid  output  1  one-cycle pulse when meas_count/freq_ok/stuck update.
REQ-012 SHALL have port freq_ok  output  1  last window within EXP_COUNT +/- TOL.
REQ-013 SHALL have port stuck  output  1  last window had zero edges.
REQ-014 SHALL have port fault  output  1  frequency fault indication.

Function
REQ-015 SHALL pass mon_clk through a 2-flop synchronizer plus a registered rising-edge detector; edge pulse latency is 3 cycles after the mon_clk rise.
REQ-016 SHALL implement FSM states IDLE, MEASURE, EVAL.
REQ-017 IDLE: window and edge counters held at 0; enable=1 moves to MEASURE on the next cycle.
REQ-018 MEASURE: window counter runs 0..GATE_CYCLES-1, edge counter increments per detected edge and saturates at 2^CNT_W-1; after cycle GATE_CYCLES-1 (edge on that cycle counted) moves to EVAL.
REQ-019 EVAL (one cycle): registers meas_count, freq_ok = (|count-EXP_COUNT| <= TOL), stuck = (count==0); outputs visible and meas_valid high on the following cycle; returns to MEASURE with counters reloaded; an edge detected during EVAL loads the edge counter with 1.
REQ-020 Measurement period SHALL be exactly GATE_CYCLES+1 cycles with enable held high.
REQ-021 The deviation comparison SHALL use CNT_W+1-bit signed arithmetic with no wrap.
REQ-022 enable falling in MEASURE or EVAL SHALL return to IDLE next cycle, discard the partial count, suppress meas_valid, clear freq_ok, and hold meas_count and stuck.
REQ-023 Without the macro, fault SHALL equal !freq_ok updated at each meas_valid, and fault_clr SHALL be ignored.

Reset
REQ-024 areset SHALL asynchronously force state IDLE, synchronizer flops, counters, meas_count, meas_valid, freq_ok, stuck and fault to 0.
REQ-025 areset mid-window SHALL discard the window; the first measurement after release completes GATE_CYCLES+1 cycles after enable is seen high.

Configuration
REQ-026 Macro CLOCK_MONITOR_STICKY_FAULT_EN defined: fault SHALL set on any failing evaluation and clear only on fault_clr; a failing evaluation coinciding with fault_clr leaves fault set.
REQ-027 Macro undefined: behaviour per REQ-023, with no sticky register present.

Structure
REQ-028 Shared package clock_monitor_pkg SHALL hold the FSM state enum and the default GATE_CYCLES/EXP_COUNT/TOL constants per monitored PLL output (PWMClock, HornClock, IMUI2CClock).
REQ-029 Synchronizer plus edge detector SHALL be a sub-module named edge_sync_detect; the rest stays in clock_monitor.

Verification
REQ-030 GATE_CYCLES=1000, EXP_COUNT=20, TOL=1, mon_clk period 50 cycles -> meas_count=20, freq_ok=1, fault=0, meas_valid every 1001 cycles.
REQ-031 mon_clk held 0 -> meas_count=0, stuck=1, freq_ok=0, fault=1.
REQ-032 mon_clk period 40 cycles (25 edges), then back to 50 -> fault=1; without the macro it falls at the next meas_valid; with the macro it stays 1 until fault_clr.
REQ-033 enable dropped at window cycle 500 -> no meas_valid, freq_ok=0, meas_count unchanged; re-enable yields next meas_valid 1001 cycles later.
REQ-034 CNT_W=4, 30 edges per window -> meas_count=15 (saturated), freq_ok per arithmetic, no wrap.
REQ-035 areset pulsed mid-window -> all outputs 0 immediately, before the next clock edge.
